// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
// Holds the FSM state encoding, default width and divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // Quotient returned when the divisor is zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/seq_divider32_if.sv
// Operand/result handshake bundle for seq_divider32.
// master: operand producer and result consumer; slave: the divider.
interface seq_divider32_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic             signed_op;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, signed_op, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, signed_op, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_addsub.sv
// Combinational W-bit adder/subtractor shared by the divider iterations.
// Ports: a_i, b_i operands; sub_i 1 = a-b, 0 = a+b; sum_o result.
module div_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o
);

    // Subtraction as a + ~b + 1 so one carry chain serves both.
    assign sum_o = a_i + (b_i ^ {W{sub_i}}) + {{(W-1){1'b0}}, sub_i};

endmodule

// File: rtl/seq_divider32.sv
// Iterative radix-2 non-restoring signed/unsigned integer divider.
// Ports: clk, rst (async, active high); bus: operand in / result out handshake.
module seq_divider32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_divider32_if.slave        bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   add_a, add_sum;
    logic             add_sub;
    logic [WIDTH-1:0] rem_mag;

    assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
    assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
    assign a_abs = a_neg ? -bus.dividend : bus.dividend;
    assign b_abs = b_neg ? -bus.divisor : bus.divisor;

    // Next dividend bit enters the partial remainder from the top of Q.
    assign shifted = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    // CALC: subtract while R is non-negative, else add back.
    // FIX: always add, used only when R ended negative.
    assign add_a   = (state_q == FIX) ? r_q : shifted;
    assign add_sub = (state_q == CALC) & ~r_q[WIDTH];

    div_addsub #(.W(WIDTH + 1)) u_addsub (
        .a_i   (add_a),
        .b_i   ({1'b0, d_q}),
        .sub_i (add_sub),
        .sum_o (add_sum)
    );

    assign rem_mag = r_q[WIDTH] ? add_sum[WIDTH-1:0] : r_q[WIDTH-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    if (bus.divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        q_d     = a_abs;
                        d_d     = b_abs;
                        r_d     = '0;
                        cnt_d   = '0;
                        qneg_d  = a_neg ^ b_neg;
                        rneg_d  = a_neg;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                r_d   = add_sum;
                q_d   = {q_q[WIDTH-2:0], ~add_sum[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quot_d  = qneg_q ? -q_q : q_q;
                rem_d   = (rneg_q && rem_mag != '0) ? -rem_mag : rem_mag;
                dbz_d   = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed and random operands
// compared against a plain-arithmetic reference divider.
module tb_seq_divider32;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider32_if #(.WIDTH(W)) bus ();

    seq_divider32 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic void model(input logic s, input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r,
                                  output logic z);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
            z = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    task automatic run_op(input logic s, input logic [31:0] a,
                          input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic z, output int lat,
                          output logic rdy_after);
        int guard;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.signed_op = s;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.in_valid  = 1'b1;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=%b want 1", bus.in_ready);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            checks++;
            failures++;
            $display("FAIL result_timeout: out_valid=%b want 1", bus.out_valid);
        end
        q = bus.quotient;
        r = bus.remainder;
        z = bus.div_by_zero;
        @(posedge clk);
        #1 rdy_after = bus.in_ready;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0) begin
            failures++;
            $display("FAIL reset_q_r: got %h/%h want 0/0",
                     bus.quotient, bus.remainder);
        end
        checks++;
        if (bus.div_by_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_dbz: got %b want 0", bus.div_by_zero);
        end
    endtask

    task automatic test_basic();
        logic [31:0] q, r;
        logic z, rdy;
        int lat;
        run_op(1'b0, 32'd100, 32'd7, q, r, z, lat, rdy);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL basic_latency: got %0d want 34", lat);
        end
        checks++;
        if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got q=%0d r=%0d z=%b want 14 2 0",
                     q, r, z);
        end
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL basic_ready_after: got %b want 1", rdy);
        end
    endtask

    task automatic test_signed();
        logic [31:0] q, r;
        logic z, rdy;
        int lat;
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, z, lat, rdy);
        checks++;
        if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || z !== 1'b0) begin
            failures++;
            $display("FAIL signed_m7_2: got q=%h r=%h z=%b want fffffffd ffffffff 0",
                     q, r, z);
        end
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, q, r, z, lat, rdy);
        checks++;
        if (q !== 32'hFFFF_FFFD || r !== 32'd1 || z !== 1'b0) begin
            failures++;
            $display("FAIL signed_7_m2: got q=%h r=%h z=%b want fffffffd 1 0",
                     q, r, z);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] q, r;
        logic z, rdy;
        int lat;
        for (int s = 0; s < 2; s++) begin
            run_op(s[0], 32'd5, 32'd0, q, r, z, lat, rdy);
            checks++;
            if (lat !== 1) begin
                failures++;
                $display("FAIL dbz_latency s=%0d: got %0d want 1", s, lat);
            end
            checks++;
            if (q !== 32'hFFFF_FFFF || r !== 32'd5 || z !== 1'b1) begin
                failures++;
                $display("FAIL dbz_result s=%0d: got q=%h r=%h z=%b want ffffffff 5 1",
                         s, q, r, z);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] q, r;
        logic z, rdy;
        int lat;
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, z, lat, rdy);
        checks++;
        if (q !== 32'h8000_0000 || r !== 32'd0 || z !== 1'b0) begin
            failures++;
            $display("FAIL ovf_signed: got q=%h r=%h z=%b want 80000000 0 0",
                     q, r, z);
        end
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, q, r, z, lat, rdy);
        checks++;
        if (q !== 32'hFFFF_FFFF || r !== 32'd0 || z !== 1'b0) begin
            failures++;
            $display("FAIL max_unsigned: got q=%h r=%h z=%b want ffffffff 0 0",
                     q, r, z);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, q, r, eq, er;
        logic s, z, ez, rdy;
        int lat, elat;
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            model(s, a, b, eq, er, ez);
            elat = (b == 32'd0) ? 1 : 34;
            run_op(s, a, b, q, r, z, lat, rdy);
            checks++;
            if (q !== eq || r !== er || z !== ez || lat !== elat) begin
                failures++;
                $display("FAIL random_%0d s=%b %h/%h: got q=%h r=%h z=%b lat=%0d want %h %h %b %0d",
                         i, s, a, b, q, r, z, lat, eq, er, ez, elat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] q0, r0;
        int guard;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd9;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd5;
        guard = 0;
        @(negedge clk);
        while (!bus.out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        q0 = bus.quotient;
        r0 = bus.remainder;
        checks++;
        if (bus.out_valid !== 1'b1 || q0 !== 32'd111 || r0 !== 32'd1) begin
            failures++;
            $display("FAIL bp_first: got v=%b q=%0d r=%0d want 1 111 1",
                     bus.out_valid, q0, r0);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.quotient !== q0 || bus.remainder !== r0) begin
                failures++;
                $display("FAIL bp_hold_%0d: got v=%b rdy=%b q=%0d r=%0d want 1 0 %0d %0d",
                         k, bus.out_valid, bus.in_ready, bus.quotient,
                         bus.remainder, q0, r0);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_after_hs: got rdy=%b v=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_second_accept: got rdy=%b want 0", bus.in_ready);
        end
        guard = 0;
        @(negedge clk);
        while (!bus.out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.quotient !== 32'd15 ||
            bus.remainder !== 32'd2) begin
            failures++;
            $display("FAIL bp_second: got v=%b q=%0d r=%0d want 1 15 2",
                     bus.out_valid, bus.quotient, bus.remainder);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int guard;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.signed_op = 1'b1;
        bus.dividend  = 32'hFFFF_FF00;
        bus.divisor   = 32'd3;
        bus.in_valid  = 1'b1;
        guard = 0;
        while (acc.size() < 2 && guard < 200) begin
            if (bus.in_ready) acc.push_back(cyc + 1);
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (acc.size() != 2 || acc[1] - acc[0] != 35) begin
            failures++;
            $display("FAIL throughput: got accepts=%0d gap=%0d want 2 35",
                     acc.size(), (acc.size() == 2) ? acc[1] - acc[0] : -1);
        end
        guard = 0;
        while (!bus.out_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] q, r;
        logic z, rdy;
        int lat, seen;
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got rdy=%b v=%b want 1 0",
                     bus.in_ready, bus.out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL mid_reset_no_output: got %0d valid cycles want 0", seen);
        end
        run_op(1'b0, 32'd9, 32'd3, q, r, z, lat, rdy);
        checks++;
        if (q !== 32'd3 || r !== 32'd0 || z !== 1'b0 || lat !== 34) begin
            failures++;
            $display("FAIL after_reset_9_3: got q=%0d r=%0d z=%b lat=%0d want 3 0 0 34",
                     q, r, z, lat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.signed_op = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        #1;
        test_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
